// File: rtl/sqrt_share_ctrl_if.sv
// Requester-side and square-root-unit-side signals of sqrt_share_ctrl.
// The controller uses the slave modport; the requesters/unit environment uses master.
interface sqrt_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_operand;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              sq_start;
  logic [W-1:0]      sq_a;
  logic [W-1:0]      sq_b;
  logic              sq_ready;

  modport master (
    output req, req_operand, sq_b, sq_ready,
    input  ack, rsp_data, rsp_err, busy, sq_start, sq_a
  );

  modport slave (
    input  req, req_operand, sq_b, sq_ready,
    output ack, rsp_data, rsp_err, busy, sq_start, sq_a
  );
endinterface

// File: rtl/sqrt_share_ctrl.sv
// Round-robin sharing of one iterative square-root unit between NREQ requesters.
// Define SQRT_SHARE_TIMEOUT_EN to bound WAIT to TIMEOUT cycles (flagged by rsp_err).
module sqrt_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input logic              clock,
  input logic              reset,
  sqrt_share_ctrl_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_chk
    $error("sqrt_share_ctrl: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  // IDLE grant | ISSUE start pulse | DRAIN skip stale ready | WAIT await ready | DONE ack
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [W-1:0]    sq_a_q, sq_a_d;
  logic            sq_start_q, sq_start_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic            expired;

`ifdef SQRT_SHARE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_DRAIN) cnt_d = '0;
    else if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign expired = 1'b0;
`endif

  // Nearest set request after last wins: scan far-to-near so the nearest overwrites.
  always_comb begin : rr_pick
    int idx;
    idx      = 0;
    pick     = last_q;
    pick_vld = 1'b0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = int'(last_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[idx[IW-1:0]]) begin
        pick     = idx[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    sq_a_d     = sq_a_q;
    sq_start_d = 1'b0;
    ack_d      = '0;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d    = S_ISSUE;
          gnt_d      = pick;
          last_d     = pick;
          sq_a_d     = bus.req_operand[pick*W +: W];
          sq_start_d = 1'b1;
        end
      end
      S_ISSUE: state_d = S_DRAIN;
      S_DRAIN: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.sq_ready) begin
          state_d        = S_DONE;
          ack_d[gnt_q]   = 1'b1;
          rsp_data_d     = bus.sq_b;
        end else if (expired) begin
          state_d        = S_DONE;
          ack_d[gnt_q]   = 1'b1;
          rsp_err_d      = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_q     <= IW'(NREQ - 1);
      gnt_q      <= '0;
      sq_a_q     <= '0;
      sq_start_q <= 1'b0;
      ack_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      sq_a_q     <= sq_a_d;
      sq_start_q <= sq_start_d;
      ack_q      <= ack_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.sq_start = sq_start_q;
  assign bus.sq_a     = sq_a_q;
endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Self-checking bench for sqrt_share_ctrl: vector table, directed corner cases,
// and randomized round-robin traffic checked against a pending-set model.
module tb_sqrt_share_ctrl;
  localparam int NREQ       = 4;
  localparam int W          = 32;
  localparam int TB_TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sqrt_share_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

  sqrt_share_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT(TB_TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Q16.16 square root by bit-wise search: floor(sqrt(a * 2^16)).
  function automatic logic [W-1:0] isqrt_q16(input logic [W-1:0] a);
    logic [63:0] x, r, t;
    x = {32'b0, a} << 16;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r[W-1:0];
  endfunction

  // Square-root unit model: ready falls two cycles after the start pulse,
  // then rises u_lat cycles later with the result and stays high.
  int          u_lat  = 0;
  int          u_dly  = 0;
  int          u_cnt  = 0;
  bit          u_pend = 1'b0;
  logic [W-1:0] u_res = '0;

  always @(negedge clock) begin
    if (u_pend) begin
      if (u_cnt == 0) begin
        bus.sq_ready = 1'b1;
        bus.sq_b     = u_res;
        u_pend       = 1'b0;
      end else u_cnt--;
    end
    if (u_dly != 0) begin
      u_dly--;
      if (u_dly == 0) begin
        bus.sq_ready = 1'b0;
        u_cnt        = u_lat;
        u_pend       = 1'b1;
      end
    end
    if (bus.sq_start === 1'b1) begin
      u_dly = 2;
      u_res = isqrt_q16(bus.sq_a);
    end
  end

  int low_run    = 0;
  bit seen_start = 1'b0;
  bit prev_start = 1'b0;
  always @(negedge clock) begin
    if (bus.sq_start === 1'b1) begin
      if (seen_start) chk("start_gap_ge3", (low_run >= 3), 1);
      chk("start_width1", prev_start, 0);
      seen_start = 1'b1;
      low_run    = 0;
    end else low_run++;
    prev_start = (bus.sq_start === 1'b1);
  end

  bit noise_en = 1'b0;
  always @(negedge clock) begin
    if (noise_en)
      for (int i = 0; i < NREQ; i++)
        if (!bus.req[i]) bus.req_operand[i*W +: W] = $urandom;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input int limit, output logic [NREQ-1:0] a, output logic [W-1:0] d,
                          output logic e, output int cyc);
    a = '0; d = '0; e = 1'b0; cyc = 0;
    while (cyc < limit) begin
      @(negedge clock);
      cyc++;
      if (bus.ack != '0) begin
        a = bus.ack; d = bus.rsp_data; e = bus.rsp_err;
        return;
      end
    end
    total++; bad++;
    $display("FAIL ack_timeout: no ack after %0d cycles, expected one", limit);
  endtask

  task automatic do_op(input int idx, input logic [W-1:0] opnd, input logic [W-1:0] exp, input int lat);
    logic [NREQ-1:0] a; logic [W-1:0] d; logic e; int cyc;
    u_lat = lat;
    bus.req_operand[idx*W +: W] = opnd;
    bus.req[idx] = 1'b1;
    @(negedge clock);
    chk("op_issue_start", bus.sq_start, 1);
    chk("op_issue_busy", bus.busy, 1);
    wait_ack(200, a, d, e, cyc);
    bus.req[idx] = 1'b0;
    chk("op_ack", a, 64'(1) << idx);
    chk("op_data", d, exp);
    chk("op_err", e, 0);
    chk("op_latency", cyc + 1, 5 + lat);
    @(negedge clock);
    chk("op_idle_busy", bus.busy, 0);
    chk("op_idle_ack", bus.ack, 0);
    chk("op_idle_data", bus.rsp_data, 0);
  endtask

  function automatic int mdl_pick(input logic [NREQ-1:0] p, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (p[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  logic [NREQ-1:0] pend;
  logic [W-1:0]    opv [NREQ];

  task automatic raise_some(input int excl);
    int j;
    for (int i = 0; i < NREQ; i++)
      if (!pend[i] && i != excl && $urandom_range(0, 1) == 1) begin
        opv[i] = $urandom;
        bus.req_operand[i*W +: W] = opv[i];
        bus.req[i] = 1'b1;
        pend[i] = 1'b1;
      end
    if (pend == '0) begin
      j = (excl + 1 + int'($urandom_range(0, NREQ - 2))) % NREQ;
      opv[j] = $urandom;
      bus.req_operand[j*W +: W] = opv[j];
      bus.req[j] = 1'b1;
      pend[j] = 1'b1;
    end
  endtask

  typedef struct {
    int           idx;
    logic [W-1:0] opnd;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  initial begin
    vec_t vecs [7];
    int   order [5];
    logic [NREQ-1:0] a; logic [W-1:0] d; logic e; int cyc;
    int   g, lat, n, mdl_last, seen_ack;

    vecs[0] = '{0, 32'h00040000, 32'h00020000, 2};
    vecs[1] = '{2, 32'h00090000, 32'h00030000, 0};
    vecs[2] = '{1, 32'h00000001, 32'h00000100, 3};
    vecs[3] = '{0, 32'hFFFFFFFF, 32'h00FFFFFF, 1};
    vecs[4] = '{2, 32'h00020000, 32'h00016A09, 5};
    vecs[5] = '{1, 32'h00000000, 32'h00000000, 0};
    vecs[6] = '{3, 32'h00100000, 32'h00040000, 2};
    order   = '{0, 1, 2, 3, 0};

    bus.req = '0; bus.req_operand = '0; bus.sq_ready = 1'b0; bus.sq_b = '0;
    pend = '0;
    repeat (3) @(negedge clock);
    chk("rst_ack", bus.ack, 0);
    chk("rst_data", bus.rsp_data, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.sq_start, 0);
    chk("rst_sq_a", bus.sq_a, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_busy", bus.busy, 0);

    for (int v = 0; v < 7; v++)
      do_op(vecs[v].idx, vecs[v].opnd, vecs[v].exp, vecs[v].lat);

    // All four requesting continuously: grants must rotate from 0.
    u_lat = 1;
    bus.req_operand = {NREQ{32'h00010000}};
    bus.req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(200, a, d, e, cyc);
      chk("fair_ack", a, 64'(1) << order[k]);
      chk("fair_data", d, 32'h00010000);
    end
    bus.req = '0;
    @(negedge clock);

    // Operand change and req drop while waiting: latched operand is used.
    u_lat = 4;
    bus.req_operand[2*W +: W] = 32'h00090000;
    bus.req[2] = 1'b1;
    repeat (3) @(negedge clock);
    chk("midop_busy", bus.busy, 1);
    bus.req_operand[2*W +: W] = 32'h00040000;
    bus.req[2] = 1'b0;
    @(negedge clock);
    chk("midop_sq_a", bus.sq_a, 32'h00090000);
    wait_ack(200, a, d, e, cyc);
    chk("midop_ack", a, 4'b0100);
    chk("midop_data", d, 32'h00030000);
    @(negedge clock);

    // Reset during WAIT abandons the operation.
    u_lat = 6;
    bus.req_operand[0 +: W] = 32'h00040000;
    bus.req[0] = 1'b1;
    repeat (3) @(negedge clock);
    chk("rwait_busy", bus.busy, 1);
    bus.req[0] = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rwait_busy0", bus.busy, 0);
    chk("rwait_sq_a0", bus.sq_a, 0);
    chk("rwait_ack0", bus.ack, 0);
    chk("rwait_data0", bus.rsp_data, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    seen_ack = 0;
    repeat (12) begin
      @(negedge clock);
      if (bus.ack != '0) seen_ack = 1;
    end
    chk("rwait_no_ack", seen_ack, 0);
    do_op(1, 32'h00100000, 32'h00040000, 2);

    // Randomized traffic against the pending-set round-robin model.
    #1 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    mdl_last = NREQ - 1;
    noise_en = 1'b1;
    raise_some(-1);
    n = 0;
    while (n < 40 || pend != '0) begin
      g = mdl_pick(pend, mdl_last);
      mdl_last = g;
      lat = int'($urandom_range(0, 5));
      u_lat = lat;
      wait_ack(300, a, d, e, cyc);
      chk("rnd_ack", a, 64'(1) << g);
      chk("rnd_data", d, isqrt_q16(opv[g]));
      chk("rnd_err", e, 0);
      chk("rnd_latency", cyc, (n == 0 ? 5 : 6) + lat);
      bus.req[g] = 1'b0;
      pend[g] = 1'b0;
      n++;
      if (n < 40) raise_some(g);
    end
    noise_en = 1'b0;
    @(negedge clock);

`ifdef SQRT_SHARE_TIMEOUT_EN
    // Unit never answers: timeout after TB_TIMEOUT WAIT cycles.
    u_lat = 100000;
    bus.req_operand[3*W +: W] = 32'h00090000;
    bus.req[3] = 1'b1;
    wait_ack(200, a, d, e, cyc);
    bus.req[3] = 1'b0;
    chk("to_ack", a, 4'b1000);
    chk("to_data", d, 0);
    chk("to_err", e, 1);
    chk("to_latency", cyc, 3 + TB_TIMEOUT);
    @(negedge clock);
    // Ready sampled in the expiry cycle wins.
    u_lat = TB_TIMEOUT - 2;
    bus.req_operand[0 +: W] = 32'h00040000;
    bus.req[0] = 1'b1;
    wait_ack(200, a, d, e, cyc);
    bus.req[0] = 1'b0;
    chk("toedge_ack", a, 4'b0001);
    chk("toedge_data", d, 32'h00020000);
    chk("toedge_err", e, 0);
    chk("toedge_latency", cyc, 3 + TB_TIMEOUT);
    @(negedge clock);
`endif

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sqrt_share_ctrl.md
Name: sqrt_share_ctrl

Overview:
- Round-robin scheduler that shares one iterative fixed-point square-root unit between NREQ requesters (e.g. normalisation, lighting and distance stages of the coprocessor).
- Latches the granted operand and drives the unit's edge-triggered start.
- Waits for the unit's level ready, then returns the result to the granted requester with a one-cycle ack.
- Sits between the requesting pipeline stages and the single square-root instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, fixed-point word width; must equal the coprocessor fixed width.
- TIMEOUT, 64, maximum cycles spent in WAIT; used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until the matching ack.
- req_operand  in  NREQ*W  requester i's operand occupies bits [i*W +: W].
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- rsp_data  out  W  result, valid only while ack is non-zero.
- rsp_err  out  1  timeout flag, valid with ack; tied 0 without the optional feature.
- busy  out  1  high in every state except IDLE.
- sq_start  out  1  start to the square-root unit; registered.
- sq_a  out  W  operand to the square-root unit; registered and held stable from ISSUE to DONE.
- sq_b  in  W  result from the square-root unit.
- sq_ready  in  1  square-root done level; stays high until the next start edge.

Behaviour:
- Reset: asynchronous. Clears all outputs to 0 and puts the FSM in IDLE. Sets the round-robin pointer last=NREQ-1, so requester 0 wins first. Reset mid-operation abandons the operation with no ack. The unit itself has no reset; the next ISSUE restarts it.
- IDLE:
  - If any req bit is set, grant g = first set index searching from last+1 upward, wrapping modulo NREQ.
  - Latch sq_a <= operand g, store g, set last <= g, go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE: sq_start=1 for exactly one cycle, then go to DRAIN.
- DRAIN: sq_start=0. sq_ready is ignored for one cycle because its value is still stale from the previous operation. Go to WAIT.
- WAIT: sq_start=0. When sq_ready=1 is sampled, register rsp_data <= sq_b, set ack[g]=1 and rsp_err=0, go to DONE.
- DONE: ack and rsp_data are valid for this one cycle. Next state is IDLE; no arbitration happens in DONE. Outputs ack=0 and rsp_data=0 from the next cycle.
- Start spacing: sq_start is low for at least 3 cycles between consecutive pulses, which guarantees the unit's previous-start register clears.
- Latency: grant cycle (IDLE) -> ISSUE -> DRAIN -> WAIT (unit compute cycles) -> DONE. Overhead is 4 cycles plus the unit's compute time.
- Back-to-back operations:
  - The minimum gap between ack pulses is 4 cycles plus compute time.
  - A requester must drop req in the cycle after its ack. If req is still high in IDLE, it is treated as a new request.
- Request changes:
  - req deasserted after grant: the operation still completes and ack still pulses.
  - req changes during busy: ignored until IDLE.
- Operand capture: req_operand is sampled only in the IDLE grant cycle; later changes have no effect.
- Fairness: with all NREQ requesters asserted, grants rotate 0,1,...,NREQ-1,0,... A requester waits at most NREQ-1 operations.
- Arithmetic: the block does no arithmetic on data. rsp_data equals sq_b bit-exactly.

Optional Feature:
- Macro: SQRT_SHARE_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to WAIT and increments each WAIT cycle.
  - If the count reaches TIMEOUT with sq_ready still 0, go to DONE with ack[g]=1, rsp_data=0 and rsp_err=1.
  - sq_ready arriving in the same cycle as expiry takes precedence and gives a normal completion.
- Undefined: no counter exists, rsp_err is constant 0, and WAIT is unbounded.

Test Plan:
- Q16.16, single request: req[0]=1, operand 0x00040000 -> ISSUE one cycle later, one sq_start pulse, then ack[0] with rsp_data=0x00020000 and rsp_err=0; busy low one cycle after DONE.
- Stale ready: leave sq_ready high after a prior operation, then issue 0x00090000 -> DRAIN ignores the stale level; rsp_data=0x00030000, not the previous result.
- Fairness: all 4 req held high, each operand 0x00010000 -> ack order 0,1,2,3,0; each rsp_data=0x00010000; sq_start gaps of at least 3 cycles.
- Mid-operation changes: change operand 2 and drop req[2] during WAIT -> result is the latched operand's root and ack[2] still pulses.
- Reset in WAIT: assert reset -> no ack, all outputs 0 immediately. After release, req[1]=1 with operand 0x00100000 -> ack[1] with rsp_data=0x00040000.
- SQRT_SHARE_TIMEOUT_EN with TIMEOUT=8: model holds sq_ready=0 -> ack[g] with rsp_err=1 and rsp_data=0 after 8 WAIT cycles. Ready arriving in the expiry cycle -> normal result with rsp_err=0.
